// File: rtl/mul_sched_if.sv
// mul_sched_if -- request/grant/result bundle between the two issue ports and
// the shared multiplier scheduler.
//   req0/a0/b0, req1/a1/b1 : port requests and signed 32-bit operands
//   gnt0/gnt1              : one-cycle grants (operands captured that cycle)
//   done0/done1            : one-cycle completion pulses to the owning port
//   result                 : 64-bit signed product, held until the next grant
//   busy                   : a multiply is in flight
// master = requester side, slave = scheduler side.
interface mul_sched_if;
  logic        req0;
  logic [31:0] a0;
  logic [31:0] b0;
  logic        req1;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [63:0] result;
  logic        busy;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, done0, done1, result, busy
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, done0, done1, result, busy
  );
endinterface

// File: rtl/mul_sched.sv
// mul_sched -- two-port round-robin scheduler and sequencer for a shared
// shift-add signed multiplier. Only one multiply is in flight at a time.
// Ports:
//   clk  : system clock, all state changes on posedge
//   rst  : synchronous active-high reset
//   bus  : mul_sched_if.slave (requests/operands in, grants/done/result/busy out)
// Sequence: IDLE (grant + capture) -> RUN (32 iterations) -> FIX (sign) -> DONE.
// Latency grant->done is 34 cycles.
// Optional feature: define MUL_EARLY_OUT_EN to skip RUN/FIX when either operand
// is zero (done one cycle after the grant, result 0).
module mul_sched (
  input  logic        clk,
  input  logic        rst,
  mul_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_mag_q;
  logic [63:0] p_q;
  logic        sign_q;
  logic        owner_q;
  logic        last_q;     // port that won the most recent grant
  logic [5:0]  cnt_q;
  logic [63:0] result_q;

  logic        gnt0, gnt1, win1;
  logic [31:0] sel_a, sel_b, a_abs, b_abs;
  logic [32:0] sum;
  logic [63:0] p_step;

  // Operands of the port that would win this cycle.
  assign sel_a = win1 ? bus.a1 : bus.a0;
  assign sel_b = win1 ? bus.b1 : bus.b0;
  // -2^31 maps to 32'h8000_0000, which is the correct unsigned magnitude.
  assign a_abs = sel_a[31] ? (~sel_a + 32'd1) : sel_a;
  assign b_abs = sel_b[31] ? (~sel_b + 32'd1) : sel_b;

  // One shift-add iteration; the carry out of the upper half is kept and
  // becomes the new MSB after the right shift.
  assign sum    = {1'b0, p_q[63:32]} + {1'b0, a_mag_q};
  assign p_step = p_q[0] ? {sum, p_q[31:1]} : {1'b0, p_q[63:1]};

`ifdef MUL_EARLY_OUT_EN
  logic op_zero;
  assign op_zero = (sel_a == 32'd0) || (sel_b == 32'd0);
`endif

  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    win1    = 1'b0;
    case (state_q)
      IDLE: begin
        // Port 1 wins when alone, or on a tie when port 0 won last time.
        win1 = bus.req1 && (!bus.req0 || !last_q);
        if (!rst && (bus.req0 || bus.req1)) begin
          gnt0 = !win1;
          gnt1 = win1;
`ifdef MUL_EARLY_OUT_EN
          state_d = op_zero ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN:     if (cnt_q == 6'd1) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_mag_q  <= '0;
      p_q      <= '0;
      sign_q   <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            a_mag_q <= a_abs;
            // Upper half is the cleared accumulator; lower half holds |b|
            // and is shifted out one bit per iteration.
            p_q     <= {32'd0, b_abs};
            sign_q  <= sel_a[31] ^ sel_b[31];
            owner_q <= win1;
            last_q  <= win1;
            cnt_q   <= 6'd32;
`ifdef MUL_EARLY_OUT_EN
            if (op_zero) result_q <= '0;
`endif
          end
        end
        RUN: begin
          p_q   <= p_step;
          cnt_q <= cnt_q - 6'd1;
        end
        FIX:     result_q <= sign_q ? (~p_q + 64'd1) : p_q;
        default: ;
      endcase
    end
  end

  assign bus.gnt0   = gnt0;
  assign bus.gnt1   = gnt1;
  assign bus.done0  = (state_q == DONE) && !owner_q;
  assign bus.done1  = (state_q == DONE) && owner_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_sched.sv
module tb_mul_sched;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic        port;
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mul_sched_if mif();

  mul_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_v;
    sa   = $signed({{32{a[31]}}, a});
    sb_v = $signed({{32{b[31]}}, b});
    return sa * sb_v;
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 34;
  endfunction

  // Drives a request and, if asked, pushes the expected outcome to the scoreboard.
  task automatic issue(input logic port, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    if (port) begin
      mif.req1 = 1'b1; mif.a1 = a; mif.b1 = b;
    end else begin
      mif.req0 = 1'b1; mif.a0 = a; mif.b0 = b;
    end
    if (push) begin
      e.port = port;
      e.prod = model_prod(a, b);
      e.lat  = model_lat(a, b);
      sb.push_back(e);
    end
  endtask

  // Observes cycles after a grant until a done pulse (bounded); no comparisons.
  task automatic wait_done(input logic clr0, input logic clr1, output int lat,
                           output logic port, output logic [63:0] res, output logic busy_ok);
    lat = -1; port = 1'b0; res = '0; busy_ok = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (clr0) mif.req0 = 1'b0;
        if (clr1) mif.req1 = 1'b0;
      end
      #1;
      if (mif.busy !== 1'b1) busy_ok = 1'b0;
      if (mif.gnt0 !== 1'b0 || mif.gnt1 !== 1'b0) busy_ok = 1'b0;
      if (mif.done0 === 1'b1 || mif.done1 === 1'b1) begin
        lat = n; port = mif.done1; res = mif.result;
        if (mif.done0 === 1'b1 && mif.done1 === 1'b1) busy_ok = 1'b0;
        break;
      end
    end
    $display("op done: port=%0d latency=%0d result=%h busy_ok=%0d", port, lat, res, busy_ok);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mif.req0 = 0; mif.req1 = 0;
    mif.a0 = '0; mif.b0 = '0; mif.a1 = '0; mif.b1 = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mif.gnt0, mif.gnt1, mif.done0, mif.done1, mif.busy} !== 5'b0 || mif.result !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b done=%b%b busy=%b result=%h, required all 0",
               mif.gnt0, mif.gnt1, mif.done0, mif.done1, mif.busy, mif.result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat; logic port; logic [63:0] res; logic bok; exp_t e;
    @(negedge clk);
    issue(1'b0, 32'd2, 32'd1, 1);
    #1;
    checks++;
    if (mif.gnt0 !== 1'b1 || mif.gnt1 !== 1'b0) begin
      errors++; $display("FAIL basic_gnt: gnt0=%b gnt1=%b, required 1 0", mif.gnt0, mif.gnt1);
    end
    wait_done(1, 1, lat, port, res, bok);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || port !== e.port || res !== e.prod) begin
      errors++; $display("FAIL basic_done: lat=%0d port=%0d result=%h, required %0d %0d %h",
                         lat, port, res, e.lat, e.port, e.prod);
    end
    checks++;
    if (bok !== 1'b1) begin
      errors++; $display("FAIL basic_busy: busy_ok=%b, required 1", bok);
    end
    @(negedge clk); #1;
    checks++;
    if (mif.busy !== 1'b0 || mif.result !== 64'h2) begin
      errors++; $display("FAIL basic_after: busy=%b result=%h, required 0 0000000000000002", mif.busy, mif.result);
    end
  endtask

  task automatic test_signed;
    int lat; logic port; logic [63:0] res; logic bok; exp_t e;
    @(negedge clk);
    issue(1'b0, -32'sd3, 32'd7, 1);
    wait_done(1, 1, lat, port, res, bok);
    e = sb.pop_front();
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFEB || res !== e.prod || port !== 1'b0 || lat !== e.lat) begin
      errors++; $display("FAIL signed_neg3x7: lat=%0d port=%0d result=%h, required %0d 0 FFFFFFFFFFFFFFEB",
                         lat, port, res, e.lat);
    end
    @(negedge clk);
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1);
    #1;
    checks++;
    if (mif.gnt1 !== 1'b1 || mif.gnt0 !== 1'b0) begin
      errors++; $display("FAIL signed_gnt1: gnt0=%b gnt1=%b, required 0 1", mif.gnt0, mif.gnt1);
    end
    wait_done(1, 1, lat, port, res, bok);
    e = sb.pop_front();
    checks++;
    if (res !== 64'h4000_0000_0000_0000 || res !== e.prod || port !== 1'b1 || bok !== 1'b1) begin
      errors++; $display("FAIL signed_minxmin: port=%0d result=%h busy_ok=%b, required 1 4000000000000000 1",
                         port, res, bok);
    end
  endtask

  task automatic test_contention;
    int lat; logic port; logic [63:0] res; logic bok; exp_t e;
    @(negedge clk);
    issue(1'b0, 32'd5, 32'd6, 1);
    issue(1'b1, -32'sd4, -32'sd4, 1);
    #1;
    checks++;
    if (mif.gnt0 !== 1'b1 || mif.gnt1 !== 1'b0) begin
      errors++; $display("FAIL cont_first_gnt: gnt0=%b gnt1=%b, required 1 0", mif.gnt0, mif.gnt1);
    end
    wait_done(1, 0, lat, port, res, bok);
    e = sb.pop_front();
    checks++;
    if (lat !== 34 || port !== e.port || res !== e.prod || res !== 64'd30) begin
      errors++; $display("FAIL cont_done0: lat=%0d port=%0d result=%h, required 34 0 %h", lat, port, res, e.prod);
    end
    @(negedge clk); #1;
    checks++;
    if (mif.gnt1 !== 1'b1 || mif.gnt0 !== 1'b0) begin
      errors++; $display("FAIL cont_gnt1_c35: gnt0=%b gnt1=%b, required 0 1", mif.gnt0, mif.gnt1);
    end
    wait_done(0, 1, lat, port, res, bok);
    e = sb.pop_front();
    checks++;
    if (lat !== 34 || port !== e.port || res !== e.prod || res !== 64'd16) begin
      errors++; $display("FAIL cont_done1: lat=%0d port=%0d result=%h, required 34 1 %h", lat, port, res, e.prod);
    end
    // Next tie must go to port 0.
    @(negedge clk);
    issue(1'b0, 32'd3, 32'd3, 1);
    issue(1'b1, 32'd4, 32'd4, 1);
    #1;
    checks++;
    if (mif.gnt0 !== 1'b1 || mif.gnt1 !== 1'b0) begin
      errors++; $display("FAIL cont_next_tie: gnt0=%b gnt1=%b, required 1 0", mif.gnt0, mif.gnt1);
    end
    wait_done(1, 0, lat, port, res, bok);
    e = sb.pop_front();
    checks++;
    if (port !== e.port || res !== e.prod) begin
      errors++; $display("FAIL cont_tie_done0: port=%0d result=%h, required %0d %h", port, res, e.port, e.prod);
    end
    @(negedge clk); #1;
    wait_done(0, 1, lat, port, res, bok);
    e = sb.pop_front();
    checks++;
    if (port !== e.port || res !== e.prod || lat !== 34) begin
      errors++; $display("FAIL cont_tie_done1: lat=%0d port=%0d result=%h, required 34 %0d %h",
                         lat, port, res, e.port, e.prod);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat; logic port; logic [63:0] res; logic bok; exp_t e;
    bit saw;
    @(negedge clk);
    issue(1'b0, 32'd7, 32'd9, 0);
    #1;
    checks++;
    if (mif.gnt0 !== 1'b1) begin
      errors++; $display("FAIL rst_mid_gnt: gnt0=%b, required 1", mif.gnt0);
    end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) mif.req0 = 1'b0;
      if (n == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({mif.gnt0, mif.gnt1, mif.done0, mif.done1, mif.busy} !== 5'b0 || mif.result !== 64'h0) begin
      errors++; $display("FAIL rst_mid_outputs: gnt=%b%b done=%b%b busy=%b result=%h, required all 0",
                         mif.gnt0, mif.gnt1, mif.done0, mif.done1, mif.busy, mif.result);
    end
    saw = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (mif.done0 === 1'b1 || mif.done1 === 1'b1 || mif.busy === 1'b1) saw = 1;
    end
    checks++;
    if (saw) begin
      errors++; $display("FAIL rst_mid_no_done: activity_seen=%0d, required 0", saw);
    end
    // Tie right after reset goes to port 0; port 1 then drops its request.
    @(negedge clk);
    issue(1'b0, 32'd11, -32'sd13, 1);
    issue(1'b1, 32'd1, 32'd1, 0);
    #1;
    checks++;
    if (mif.gnt0 !== 1'b1 || mif.gnt1 !== 1'b0) begin
      errors++; $display("FAIL rst_tie_gnt: gnt0=%b gnt1=%b, required 1 0", mif.gnt0, mif.gnt1);
    end
    wait_done(1, 1, lat, port, res, bok);
    e = sb.pop_front();
    checks++;
    if (port !== e.port || res !== e.prod || lat !== e.lat) begin
      errors++; $display("FAIL rst_after_done: lat=%0d port=%0d result=%h, required %0d %0d %h",
                         lat, port, res, e.lat, e.port, e.prod);
    end
    saw = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #1;
      if (mif.gnt1 === 1'b1 || mif.busy === 1'b1) saw = 1;
    end
    checks++;
    if (saw) begin
      errors++; $display("FAIL dropped_req: activity_seen=%0d, required 0", saw);
    end
  endtask

  task automatic test_early_out;
    int lat; logic port; logic [63:0] res; logic bok; exp_t e;
    @(negedge clk);
    issue(1'b0, 32'd0, 32'd12345, 1);
    wait_done(1, 1, lat, port, res, bok);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || res !== 64'h0 || port !== 1'b0) begin
      errors++; $display("FAIL early_out: lat=%0d port=%0d result=%h, required %0d 0 0", lat, port, res, e.lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic port; logic [63:0] res; logic bok; exp_t e;
    logic [31:0] av [8];
    logic [31:0] bv [8];
    av[0] = 32'h8000_0000; bv[0] = 32'hFFFF_FFFF;
    av[1] = 32'h7FFF_FFFF; bv[1] = 32'h7FFF_FFFF;
    av[2] = 32'hFFFF_FFFF; bv[2] = 32'hFFFF_FFFF;
    av[3] = 32'h8000_0000; bv[3] = 32'h7FFF_FFFF;
    for (int i = 4; i < 8; i++) begin
      av[i] = $urandom | 32'd1;
      bv[i] = $urandom | 32'd1;
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      issue(i[0], av[i], bv[i], 1);
      #1;
      checks++;
      if ((i[0] ? mif.gnt1 : mif.gnt0) !== 1'b1) begin
        errors++; $display("FAIL b2b_gnt[%0d]: gnt0=%b gnt1=%b, required port %0d", i, mif.gnt0, mif.gnt1, i[0]);
      end
      wait_done(1, 1, lat, port, res, bok);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || port !== e.port || res !== e.prod || bok !== 1'b1) begin
        errors++; $display("FAIL b2b_done[%0d]: a=%h b=%h lat=%0d port=%0d result=%h busy_ok=%b, required %0d %0d %h 1",
                           i, av[i], bv[i], lat, port, res, bok, e.lat, e.port, e.prod);
      end
      @(negedge clk);  // DONE->IDLE cycle: earliest next grant
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_contention;
    test_reset_mid_op;
    test_early_out;
    test_back_to_back;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: remaining=%0d, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
